repair_rx_multi: RTL and testbench
==================================

Name: repair_rx_multi

Overview:
- Parametrised receive-side responder for the MBTRAIN repair sub-step.
- Waits for the partner's INIT, APPLY_DEGRADE and END requests over sideband and answers each with its response.
- Decodes the APPLY_DEGRADE lane-group encoding into a per-group result vector. Differs from the earlier fixed 2-group design: N groups, a response handshake on every step, a wait timeout and an invalid-encoding flag.
- Sits under the MBTRAIN controller, beside the repair TX responder, and shares the sideband request/valid path with it.

Parameters:
- NUM_GROUPS, 2, number of lane groups reported (1..8).
- ENC_W, 3, width of the lane-group encoding field; must be >= NUM_GROUPS.
- MSG_W, 4, sideband message code width.
- TIMEOUT_CYCLES, 1000, clk cycles allowed in any wait state before timeout; >= 2.
- CNT_W, 10, timeout counter width; >= clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_en  in  1  enable from MBTRAIN; low forces IDLE next clk.
- i_sb_msg  in  MSG_W  received sideband message code.
- i_sb_enc  in  ENC_W  lane-group encoding carried with the message.
- i_sb_valid  in  1  i_sb_msg/i_sb_enc valid this cycle.
- i_busy_negedge  in  1  sideband finished sending the current message.
- i_valid_tx  in  1  TX responder currently owns the sideband request.
- o_sb_msg  out  MSG_W  response code to send.
- o_valid_rx  out  1  request to sideband to send o_sb_msg.
- o_group_ok  out  NUM_GROUPS  per-group partner result (1 = usable).
- o_enc_invalid  out  1  last APPLY_DEGRADE encoding was illegal.
- o_test_ack  out  1  repair handshake completed.
- o_timeout  out  1  wait-state timeout occurred.

Behaviour:
- Codes:
  - INIT_REQ=1, INIT_RSP=2.
  - END_REQ=5, END_RSP=6.
  - DEGRADE_REQ=7, DEGRADE_RSP=8.
  - Zero-extended to MSG_W.
- Reset values: all outputs 0. Internal state is IDLE, the counter is 0 and the pending flag is 0.
- States: IDLE, WAIT_INIT, RSP_INIT, WAIT_DEGRADE, RSP_DEGRADE, WAIT_END, RSP_END, DONE, TIMEOUT.
- Global: i_en=0 moves to IDLE on the next edge from any state, clearing o_valid_rx, the pending flag, o_test_ack and o_timeout. o_group_ok and o_enc_invalid hold.
- IDLE to WAIT_INIT when i_en=1. On this edge o_group_ok and o_enc_invalid clear to 0.
- WAIT_x to RSP_x on i_sb_valid with the matching request code. On the same edge o_sb_msg takes the matching response code and pending is set. Any other message is ignored.
- WAIT_DEGRADE decode, using i_sb_enc:
  - Legal: i_sb_enc nonzero and bits >= NUM_GROUPS are zero. Then o_group_ok <= i_sb_enc[NUM_GROUPS-1:0] and o_enc_invalid <= 0.
  - Otherwise: o_group_ok <= 0 and o_enc_invalid <= 1.
  - Either way the response is still sent.
- Valid handshake:
  - o_valid_rx rises on the first edge where pending=1 and i_valid_tx=0. While i_valid_tx=1 it is deferred with no lost request.
  - o_valid_rx falls on i_busy_negedge. This clears pending and advances the state:
    - RSP_INIT to WAIT_DEGRADE.
    - RSP_DEGRADE to WAIT_END.
    - RSP_END to DONE, with o_test_ack <= 1 and o_sb_msg <= 0.
  - i_busy_negedge while o_valid_rx=0 is ignored.
- DONE: holds o_test_ack=1 until i_en=0.
- Timeout:
  - The counter clears on every state change and increments each cycle in WAIT_INIT, WAIT_DEGRADE and WAIT_END.
  - Reaching TIMEOUT_CYCLES-1 without a match moves to TIMEOUT with o_timeout <= 1. TIMEOUT is held until i_en=0.
  - RSP_x states are not timed.
  - A match on the expiry cycle wins over the timeout.
- Reset mid-operation: async return to the reset values, with no partial response.

Optional Feature:
- Macro REPAIR_RX_RETRY_EN.
- Defined: in WAIT_DEGRADE, a repeated INIT_REQ re-sends INIT_RSP (enters RSP_INIT). In WAIT_END, a repeated DEGRADE_REQ re-decodes the encoding and enters RSP_DEGRADE. The timeout counter clears on each retry.
- Undefined: repeated earlier requests are ignored.

Test Plan:
- NUM_GROUPS=2, INIT_REQ, DEGRADE_REQ with enc=3'b011, then END_REQ, each followed by i_busy_negedge. Required: responses 2, 8 and 6 each present with o_valid_rx for exactly one handshake; then o_group_ok=2'b11, o_test_ack=1 and o_sb_msg=0.
- DEGRADE_REQ enc=3'b100 with NUM_GROUPS=2 -> o_enc_invalid=1, o_group_ok=0, DEGRADE_RSP still sent.
- i_valid_tx=1 for 5 cycles when the INIT_REQ match occurs -> o_valid_rx rises one edge after i_valid_tx falls; o_sb_msg=2 held throughout.
- No request for TIMEOUT_CYCLES=1000 cycles in WAIT_INIT -> o_timeout=1 at cycle 1000; i_en=0 -> IDLE, o_timeout=0.
- rst_n low while in RSP_DEGRADE with o_valid_rx=1 -> all outputs 0 immediately.
- REPAIR_RX_RETRY_EN defined, INIT_REQ repeated in WAIT_DEGRADE -> second INIT_RSP sent; without the macro -> no o_valid_rx.

Source files
------------

// File: rtl/repair_rx_multi.sv
// Receive-side responder for the MBTRAIN repair sub-step: answers INIT/APPLY_DEGRADE/END requests.
// Optional REPAIR_RX_RETRY_EN lets a repeated earlier request re-enter its response state.
module repair_rx_multi #(
  parameter int NUM_GROUPS     = 2,
  parameter int ENC_W          = 3,
  parameter int MSG_W          = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [MSG_W-1:0]      i_sb_msg,
  input  logic [ENC_W-1:0]      i_sb_enc,
  input  logic                  i_sb_valid,
  input  logic                  i_busy_negedge,
  input  logic                  i_valid_tx,
  output logic [MSG_W-1:0]      o_sb_msg,
  output logic                  o_valid_rx,
  output logic [NUM_GROUPS-1:0] o_group_ok,
  output logic                  o_enc_invalid,
  output logic                  o_test_ack,
  output logic                  o_timeout
);
  // state        | meaning
  // IDLE         | disabled, waiting for i_en
  // WAIT_INIT    | waiting for INIT_REQ (timed)
  // RSP_INIT     | sending INIT_RSP
  // WAIT_DEGRADE | waiting for DEGRADE_REQ (timed)
  // RSP_DEGRADE  | sending DEGRADE_RSP
  // WAIT_END     | waiting for END_REQ (timed)
  // RSP_END      | sending END_RSP
  // DONE         | handshake complete, ack held
  // TIMEOUT      | a wait state expired, held until i_en drops
  typedef enum logic [3:0] {
    IDLE, WAIT_INIT, RSP_INIT, WAIT_DEGRADE, RSP_DEGRADE, WAIT_END, RSP_END, DONE, TIMEOUT
  } state_t;

  localparam logic [MSG_W-1:0] INIT_REQ    = MSG_W'(1);
  localparam logic [MSG_W-1:0] INIT_RSP    = MSG_W'(2);
  localparam logic [MSG_W-1:0] END_REQ     = MSG_W'(5);
  localparam logic [MSG_W-1:0] END_RSP     = MSG_W'(6);
  localparam logic [MSG_W-1:0] DEGRADE_REQ = MSG_W'(7);
  localparam logic [MSG_W-1:0] DEGRADE_RSP = MSG_W'(8);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pending;

  logic req_init, req_degrade, req_end, expired, enc_legal;
  state_t rsp_next;

  assign req_init    = i_sb_valid && (i_sb_msg == INIT_REQ);
  assign req_degrade = i_sb_valid && (i_sb_msg == DEGRADE_REQ);
  assign req_end     = i_sb_valid && (i_sb_msg == END_REQ);
  assign expired     = (cnt == CNT_LAST);
  // Legal encoding: at least one group usable and nothing set above the implemented groups.
  assign enc_legal   = (i_sb_enc != '0) && ((i_sb_enc >> NUM_GROUPS) == '0);

  always_comb begin
    rsp_next = IDLE;
    case (state)
      RSP_INIT:    rsp_next = WAIT_DEGRADE;
      RSP_DEGRADE: rsp_next = WAIT_END;
      RSP_END:     rsp_next = DONE;
      default:     rsp_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      pending       <= 1'b0;
      o_sb_msg      <= '0;
      o_valid_rx    <= 1'b0;
      o_group_ok    <= '0;
      o_enc_invalid <= 1'b0;
      o_test_ack    <= 1'b0;
      o_timeout     <= 1'b0;
    end else if (!i_en) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      o_valid_rx <= 1'b0;
      o_test_ack <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state         <= WAIT_INIT;
          cnt           <= '0;
          o_group_ok    <= '0;
          o_enc_invalid <= 1'b0;
        end
        WAIT_INIT: begin
          if (req_init) begin
            state    <= RSP_INIT;
            o_sb_msg <= INIT_RSP;
            pending  <= 1'b1;
            cnt      <= '0;
          end else if (expired) begin
            state     <= TIMEOUT;
            o_timeout <= 1'b1;
            cnt       <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_DEGRADE: begin
          if (req_degrade) begin
            state         <= RSP_DEGRADE;
            o_sb_msg      <= DEGRADE_RSP;
            pending       <= 1'b1;
            cnt           <= '0;
            o_group_ok    <= enc_legal ? i_sb_enc[NUM_GROUPS-1:0] : '0;
            o_enc_invalid <= !enc_legal;
          end
`ifdef REPAIR_RX_RETRY_EN
          else if (req_init) begin
            state    <= RSP_INIT;
            o_sb_msg <= INIT_RSP;
            pending  <= 1'b1;
            cnt      <= '0;
          end
`endif
          else if (expired) begin
            state     <= TIMEOUT;
            o_timeout <= 1'b1;
            cnt       <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_END: begin
          if (req_end) begin
            state    <= RSP_END;
            o_sb_msg <= END_RSP;
            pending  <= 1'b1;
            cnt      <= '0;
          end
`ifdef REPAIR_RX_RETRY_EN
          else if (req_degrade) begin
            state         <= RSP_DEGRADE;
            o_sb_msg      <= DEGRADE_RSP;
            pending       <= 1'b1;
            cnt           <= '0;
            o_group_ok    <= enc_legal ? i_sb_enc[NUM_GROUPS-1:0] : '0;
            o_enc_invalid <= !enc_legal;
          end
`endif
          else if (expired) begin
            state     <= TIMEOUT;
            o_timeout <= 1'b1;
            cnt       <= '0;
          end else cnt <= cnt + 1'b1;
        end
        RSP_INIT, RSP_DEGRADE, RSP_END: begin
          // The request is held in pending while the TX responder owns the sideband.
          if (o_valid_rx && i_busy_negedge) begin
            o_valid_rx <= 1'b0;
            pending    <= 1'b0;
            cnt        <= '0;
            state      <= rsp_next;
            if (state == RSP_END) begin
              o_test_ack <= 1'b1;
              o_sb_msg   <= '0;
            end
          end else if (pending && !o_valid_rx && !i_valid_tx) begin
            o_valid_rx <= 1'b1;
          end
        end
        DONE, TIMEOUT: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_repair_rx_multi.sv
// Randomized self-checking bench for repair_rx_multi against a request/response reference model.
// Honours REPAIR_RX_RETRY_EN when choosing expectations for repeated requests.
module tb_repair_rx_multi;
  localparam int NG = 2, EW = 3, MW = 4, TO = 1000, CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_en = 1'b0;
  logic [MW-1:0] i_sb_msg = '0;
  logic [EW-1:0] i_sb_enc = '0;
  logic          i_sb_valid = 1'b0;
  logic          i_busy_negedge = 1'b0;
  logic          i_valid_tx = 1'b0;
  logic [MW-1:0] o_sb_msg;
  logic          o_valid_rx;
  logic [NG-1:0] o_group_ok;
  logic          o_enc_invalid;
  logic          o_test_ack;
  logic          o_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int junk_codes[13] = '{0, 2, 3, 4, 6, 8, 9, 10, 11, 12, 13, 14, 15};
`ifdef REPAIR_RX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  repair_rx_multi #(.NUM_GROUPS(NG), .ENC_W(EW), .MSG_W(MW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_sb_msg(i_sb_msg), .i_sb_enc(i_sb_enc),
    .i_sb_valid(i_sb_valid), .i_busy_negedge(i_busy_negedge), .i_valid_tx(i_valid_tx),
    .o_sb_msg(o_sb_msg), .o_valid_rx(o_valid_rx), .o_group_ok(o_group_ok),
    .o_enc_invalid(o_enc_invalid), .o_test_ack(o_test_ack), .o_timeout(o_timeout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: an encoding is usable iff 0 < enc < 2**NG; then each bit is a group result.
  function automatic int model_ok(input int enc);
    return (enc > 0 && enc < (1 << NG)) ? enc : 0;
  endfunction
  function automatic int model_inv(input int enc);
    return (enc > 0 && enc < (1 << NG)) ? 0 : 1;
  endfunction

  task automatic restart();
    @(negedge clk); i_en = 1'b0;
    @(negedge clk); i_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      i_sb_msg       = MW'(junk_codes[$urandom_range(0, 12)]);
      i_sb_enc       = EW'($urandom);
      i_sb_valid     = 1'($urandom);
      i_busy_negedge = 1'($urandom);
      @(negedge clk);
    end
    i_sb_valid = 1'b0; i_busy_negedge = 1'b0; i_sb_msg = '0;
  endtask

  task automatic exchange(input int req, input int enc, input int rsp, input int tx_hold);
    i_valid_tx = (tx_hold > 0);
    i_sb_msg = MW'(req); i_sb_enc = EW'(enc); i_sb_valid = 1'b1;
    @(negedge clk);
    i_sb_valid = 1'b0; i_sb_msg = '0;
    chk("rsp_code", 32'(o_sb_msg), 32'(rsp));
    chk("valid_pre", 32'(o_valid_rx), 0);
    for (int i = 1; i < tx_hold; i++) begin
      i_busy_negedge = 1'($urandom);
      @(negedge clk);
      chk("valid_defer", 32'(o_valid_rx), 0);
      chk("msg_defer", 32'(o_sb_msg), 32'(rsp));
    end
    i_busy_negedge = 1'b0; i_valid_tx = 1'b0;
    @(negedge clk);
    chk("valid_rise", 32'(o_valid_rx), 1);
    chk("msg_valid", 32'(o_sb_msg), 32'(rsp));
    for (int i = $urandom_range(0, 3); i > 0; i--) begin
      @(negedge clk);
      chk("valid_hold", 32'(o_valid_rx), 1);
    end
    i_busy_negedge = 1'b1;
    @(negedge clk);
    i_busy_negedge = 1'b0;
    chk("valid_fall", 32'(o_valid_rx), 0);
  endtask

  task automatic run_flow(input int enc, input int tx_init);
    restart();
    chk("grp_clear", 32'(o_group_ok), 0);
    chk("inv_clear", 32'(o_enc_invalid), 0);
    junk($urandom_range(0, 6));
    exchange(1, 0, 2, tx_init);
    junk($urandom_range(0, 6));
    exchange(7, enc, 8, $urandom_range(0, 3));
    chk("grp_ok", 32'(o_group_ok), 32'(model_ok(enc)));
    chk("enc_inv", 32'(o_enc_invalid), 32'(model_inv(enc)));
    junk($urandom_range(0, 6));
    exchange(5, 0, 6, $urandom_range(0, 3));
    chk("ack_done", 32'(o_test_ack), 1);
    chk("msg_done", 32'(o_sb_msg), 0);
    junk(2);
    chk("ack_hold", 32'(o_test_ack), 1);
    i_en = 1'b0;
    @(negedge clk);
    chk("ack_off", 32'(o_test_ack), 0);
    chk("grp_hold", 32'(o_group_ok), 32'(model_ok(enc)));
  endtask

  initial begin
    #12;
    chk("rst_msg", 32'(o_sb_msg), 0);
    chk("rst_valid", 32'(o_valid_rx), 0);
    chk("rst_grp", 32'({o_group_ok, o_enc_invalid, o_test_ack, o_timeout}), 0);
    @(negedge clk); rst_n = 1'b1;

    run_flow(3, 0);
    run_flow(4, 2);
    run_flow(1, 5);
    for (int k = 0; k < 20; k++) run_flow($urandom_range(0, 7), $urandom_range(0, 4));

    // timeout in WAIT_INIT
    restart();
    repeat (TO - 1) @(negedge clk);
    chk("to_early", 32'(o_timeout), 0);
    @(negedge clk);
    chk("to_fire", 32'(o_timeout), 1);
    i_en = 1'b0;
    @(negedge clk);
    chk("to_clear", 32'(o_timeout), 0);

    // a match on the expiry cycle beats the timeout
    restart();
    repeat (TO - 1) @(negedge clk);
    i_sb_msg = 4'd1; i_sb_valid = 1'b1;
    @(negedge clk);
    i_sb_valid = 1'b0; i_sb_msg = '0;
    chk("to_match", 32'(o_timeout), 0);
    chk("to_match_msg", 32'(o_sb_msg), 2);
    @(negedge clk);
    chk("to_match_valid", 32'(o_valid_rx), 1);
    i_busy_negedge = 1'b1; @(negedge clk); i_busy_negedge = 1'b0;

    // async reset while DEGRADE_RSP is being requested
    restart();
    exchange(1, 0, 2, 0);
    i_sb_msg = 4'd7; i_sb_enc = 3'd3; i_sb_valid = 1'b1;
    @(negedge clk);
    i_sb_valid = 1'b0; i_sb_msg = '0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(o_valid_rx), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_msg", 32'(o_sb_msg), 0);
    chk("arst_valid", 32'(o_valid_rx), 0);
    chk("arst_rest", 32'({o_group_ok, o_enc_invalid, o_test_ack, o_timeout}), 0);
    @(negedge clk); rst_n = 1'b1;

    // repeated INIT_REQ while waiting for DEGRADE_REQ
    restart();
    exchange(1, 0, 2, 0);
    i_sb_msg = 4'd1; i_sb_valid = 1'b1;
    @(negedge clk);
    i_sb_valid = 1'b0; i_sb_msg = '0;
    @(negedge clk);
    chk("retry_valid", 32'(o_valid_rx), 32'(RETRY));
    chk("retry_msg", 32'(o_sb_msg), 2);
    i_busy_negedge = 1'b1; @(negedge clk); i_busy_negedge = 1'b0;
    chk("retry_fall", 32'(o_valid_rx), 0);
    i_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
